// File: rtl/serial_sub_if.sv
// -----------------------------------------------------------------------------
// serial_sub_if
//
// Handshake bundle for the bit-serial subtractor.
//
//   in_valid / in_ready   : operand handshake (producer -> subtractor)
//   a, b                  : minuend and subtrahend, WIDTH bits each
//   out_valid / out_ready : result handshake (subtractor -> consumer)
//   d                     : difference, WIDTH bits
//   bout                  : final borrow (a < b unsigned)
//   ovf                   : signed overflow, only present when the macro
//                           SERIAL_SUB_OVF_EN is defined
//
// Modports:
//   master : the side that supplies operands and consumes results
//   slave  : the subtractor itself
//
// The WIDTH parameter must match the WIDTH of the serial_sub instance that
// receives the slave modport.
// -----------------------------------------------------------------------------
interface serial_sub_if #(
   parameter int WIDTH = 8
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] d;
   logic             bout;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;
`endif

   // Producer/consumer view of the subtractor.
   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, d, bout
`ifdef SERIAL_SUB_OVF_EN
      , input ovf
`endif
   );

   // The subtractor's own view.
   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, d, bout
`ifdef SERIAL_SUB_OVF_EN
      , output ovf
`endif
   );

endinterface

// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub
//
// Bit-serial subtractor computing a - b one bit per clock, LSB first, through
// a single full-subtractor cell and a borrow flop. Operands arrive on a
// valid/ready handshake; the result is held on an output valid/ready
// handshake until the consumer takes it.
//
// Parameters:
//   WIDTH     : operand/result width, 2 or more (default 8)
//
// Ports:
//   clk       : clock, rising edge active
//   rst_n     : asynchronous active-low reset
//   bus       : serial_sub_if.slave
//                 in_valid/in_ready, a, b     operand handshake
//                 out_valid/out_ready, d, bout result handshake
//                 ovf                         signed overflow (optional)
//
// Optional feature:
//   SERIAL_SUB_OVF_EN - when defined, the MSBs of both operands are captured
//   on accept and a signed-overflow flag is presented with the result. When
//   undefined, neither the flag nor the capture flops exist; d and bout are
//   unaffected.
//
// Timing: accept at edge E0, bits computed on E1..E(WIDTH), result valid
// after E(WIDTH). With in_valid and out_ready held high one result is
// produced every WIDTH+2 cycles. All handshake outputs come straight from
// flops, so there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module serial_sub #(
   parameter int WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   serial_sub_if.slave bus
);

   // The bit counter only has to reach WIDTH-1, so ceil(log2(WIDTH)) bits
   // suffice and it never wraps inside one operation.
   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] r;
   logic             br;
   logic [CNT_W-1:0] cnt;
   logic             in_ready_q;
   logic             out_valid_q;

`ifdef SERIAL_SUB_OVF_EN
   logic             a_msb;
   logic             b_msb;
   logic             ovf_q;
`endif

   logic             dbit;
   logic             br_next;

   // Full-subtractor cell working on the current LSBs of the operand shift
   // registers. A borrow is generated when the minuend bit is 0 and the
   // subtrahend bit is 1, and an incoming borrow propagates when the two
   // bits are equal.
   always_comb begin
      dbit    = sa[0] ^ sb[0] ^ br;
      br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
   end

   // Control FSM and datapath in one sequential block. The handshake
   // outputs are kept as their own flops and are updated together with the
   // state transition, so they always agree with the state.
   //
   // In RUN the operands shift right so bit i reaches position 0 on the
   // i-th step, and each new difference bit enters R at the top; after
   // WIDTH steps the LSB computed first has travelled down to R[0].
   //
   // With the overflow option, the flag is formed on the last RUN edge from
   // the bit entering R's MSB, so it becomes visible together with
   // out_valid and is cleared again when the result is handed off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         sa          <= '0;
         sb          <= '0;
         r           <= '0;
         br          <= 1'b0;
         cnt         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb       <= 1'b0;
         b_msb       <= 1'b0;
         ovf_q       <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sa         <= bus.a;
                  sb         <= bus.b;
                  br         <= 1'b0;
                  cnt        <= '0;
                  in_ready_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                  a_msb      <= bus.a[WIDTH-1];
                  b_msb      <= bus.b[WIDTH-1];
`endif
                  state      <= RUN;
               end
            end

            RUN: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               r   <= {dbit, r[WIDTH-1:1]};
               br  <= br_next;
               cnt <= cnt + CNT_ONE;
               if (cnt == CNT_LAST) begin
                  out_valid_q <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                  ovf_q       <= (a_msb != b_msb) && (dbit != a_msb);
`endif
                  state       <= DONE;
               end
            end

            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                  ovf_q       <= 1'b0;
`endif
                  state       <= IDLE;
               end
            end

            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
               ovf_q       <= 1'b0;
`endif
               state       <= IDLE;
            end
         endcase
      end
   end

   // Every output is a flop; R and the borrow flop are only frozen while
   // out_valid is high, which is the only time they are meaningful.
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.d         = r;
   assign bus.bout      = br;
`ifdef SERIAL_SUB_OVF_EN
   assign bus.ovf       = ovf_q;
`endif

endmodule
